// File: rtl/data_mem_initiator_pkg.sv
// Shared definitions for the CPU data-memory initiator: FSM encoding and the
// default block-RAM geometry/latency.
package data_mem_initiator_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StResp   = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_ADDR_BITS  = 12;
    localparam int unsigned DMEM_RD_LATENCY = 1;

endpackage

// File: rtl/data_mem_initiator.sv
// Data-memory initiator: turns CPU load/store requests into block-RAM accesses,
// waits out the RAM read latency and returns a valid/ready response.
module data_mem_initiator
    import data_mem_initiator_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DMEM_ADDR_BITS,
    parameter int unsigned RD_LATENCY = DMEM_RD_LATENCY
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_Data,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_Data,
    output logic        Rsp_Fault,
    output logic [29:0] Mem_Addr,
    output logic        Mem_En_W,
    output logic        Mem_En_R,
    output logic [31:0] Mem_Data_W,
    input  logic [31:0] Mem_Data_R
);

    localparam logic [1:0] CntInit = 2'(RD_LATENCY - 1);

    dmem_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic        accept, addr_ok;

    assign Req_Ready = Reset_n & ((state_q == StIdle) | ((state_q == StResp) & Rsp_Ready));
    assign accept    = Req_Valid & Req_Ready;
    assign addr_ok   = (Req_Addr[1:0] == 2'b00) & (Req_Addr[31:ADDR_BITS+2] == '0);

    // Memory port follows the request directly; only the enables are qualified.
    assign Mem_Addr   = 30'(Req_Addr[ADDR_BITS+1:2]);
    assign Mem_Data_W = Req_Data;
    assign Mem_En_W   = accept & addr_ok & Req_Write;
    assign Mem_En_R   = accept & addr_ok & ~Req_Write;

    assign Rsp_Valid = (state_q == StResp);
    assign Rsp_Data  = data_q;
    assign Rsp_Fault = fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    data_d  = '0;
                    fault_d = ~addr_ok;
                    if (addr_ok & ~Req_Write) begin
                        state_d = StRdWait;
                        cnt_d   = CntInit;
                    end else begin
                        state_d = StResp;
                    end
                end else if ((state_q == StResp) & Rsp_Ready) begin
                    state_d = StIdle;
                    data_d  = '0;
                    fault_d = 1'b0;
                end
            end
            StRdWait: begin
                if (cnt_q == 2'd0) begin
                    data_d  = Mem_Data_R;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_data_mem_initiator.sv
// Self-checking bench for data_mem_initiator: RAM models, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_data_mem_initiator;

    localparam int AW     = 12;
    localparam int WORDS  = 4096;
    localparam int RD_LAT = 1;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req_Valid, Req_Ready, Req_Write;
    logic [31:0] Req_Addr, Req_Data;
    logic        Rsp_Valid, Rsp_Ready, Rsp_Fault;
    logic [31:0] Rsp_Data;
    logic [29:0] Mem_Addr;
    logic        Mem_En_W, Mem_En_R;
    logic [31:0] Mem_Data_W, Mem_Data_R;

    logic        Req_Valid3, Req_Ready3, Req_Write3;
    logic [31:0] Req_Addr3, Req_Data3;
    logic        Rsp_Valid3, Rsp_Ready3, Rsp_Fault3;
    logic [31:0] Rsp_Data3;
    logic [29:0] Mem_Addr3;
    logic        Mem_En_W3, Mem_En_R3;
    logic [31:0] Mem_Data_W3, Mem_Data_R3;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    data_mem_initiator u_dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Addr(Req_Addr), .Req_Data(Req_Data),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
        .Rsp_Fault(Rsp_Fault), .Mem_Addr(Mem_Addr), .Mem_En_W(Mem_En_W),
        .Mem_En_R(Mem_En_R), .Mem_Data_W(Mem_Data_W), .Mem_Data_R(Mem_Data_R)
    );

    data_mem_initiator #(.RD_LATENCY(3)) u_dut3 (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req_Valid(Req_Valid3), .Req_Ready(Req_Ready3), .Req_Write(Req_Write3),
        .Req_Addr(Req_Addr3), .Req_Data(Req_Data3),
        .Rsp_Valid(Rsp_Valid3), .Rsp_Ready(Rsp_Ready3), .Rsp_Data(Rsp_Data3),
        .Rsp_Fault(Rsp_Fault3), .Mem_Addr(Mem_Addr3), .Mem_En_W(Mem_En_W3),
        .Mem_En_R(Mem_En_R3), .Mem_Data_W(Mem_Data_W3), .Mem_Data_R(Mem_Data_R3)
    );

    function automatic logic [31:0] init_word(input int unsigned idx);
        return 32'h5A00_0000 ^ (idx * 32'h0001_0003);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Latency-1 RAM; unwritten words read as init_word()
    logic [31:0] ram [WORDS];
    bit          ram_wr [WORDS];
    logic [31:0] ram_rd;
    assign Mem_Data_R = ram_rd;

    always @(posedge Clock) begin
        if (Mem_En_W) begin
            ram[Mem_Addr[AW-1:0]]    <= Mem_Data_W;
            ram_wr[Mem_Addr[AW-1:0]] <= 1'b1;
        end
        if (Mem_En_R)
            ram_rd <= ram_wr[Mem_Addr[AW-1:0]] ? ram[Mem_Addr[AW-1:0]]
                                               : init_word(Mem_Addr[AW-1:0]);
    end

    // Latency-3 read-only RAM for the second instance
    logic [31:0] r3_pipe [3];
    assign Mem_Data_R3 = r3_pipe[2];

    always @(posedge Clock) begin
        if (Mem_En_R3) r3_pipe[0] <= init_word(Mem_Addr3[AW-1:0]);
        r3_pipe[1] <= r3_pipe[0];
        r3_pipe[2] <= r3_pipe[1];
    end

    // Reference model: one outstanding response plus a countdown until it shows
    logic [31:0] m_mem [WORDS];
    bit          m_wr [WORDS];
    bit          m_pend = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_data = '0;
    bit          m_fault = 1'b0;
    bit          n_pend, n_fault, n_we;
    int          n_wait, n_idx;
    logic [31:0] n_data, n_wdata;
    int          rsp_hs = 0;

    always @(negedge Clock) begin : compare
        bit e_ready, e_valid, acc, ok;
        int idx;
        e_ready = Reset_n && (!m_pend || (m_wait == 0 && Rsp_Ready));
        e_valid = m_pend && (m_wait == 0);
        acc     = Req_Valid && e_ready;
        ok      = (Req_Addr % 4 == 0) && (Req_Addr < (32'd4 << AW));
        idx     = int'(Req_Addr / 4);
        check("req_ready", 32'(Req_Ready), 32'(e_ready));
        check("rsp_valid", 32'(Rsp_Valid), 32'(e_valid));
        check("mem_en_w", 32'(Mem_En_W), 32'(acc && ok && Req_Write));
        check("mem_en_r", 32'(Mem_En_R), 32'(acc && ok && !Req_Write));
        if (acc && ok) check("mem_addr", 32'(Mem_Addr), idx);
        if (acc && ok && Req_Write) check("mem_data_w", Mem_Data_W, Req_Data);
        if (e_valid) begin
            check("rsp_data", Rsp_Data, m_data);
            check("rsp_fault", 32'(Rsp_Fault), 32'(m_fault));
            if (Rsp_Ready) rsp_hs++;
        end
        n_pend  = m_pend;
        n_wait  = m_wait;
        n_data  = m_data;
        n_fault = m_fault;
        n_we    = 1'b0;
        n_idx   = idx;
        n_wdata = Req_Data;
        if (acc) begin
            n_pend  = 1'b1;
            n_wait  = 0;
            n_data  = '0;
            n_fault = !ok;
            if (ok && Req_Write) begin
                n_we = 1'b1;
            end else if (ok) begin
                n_wait = RD_LAT;
                n_data = m_wr[idx] ? m_mem[idx] : init_word(idx);
            end
        end else if (m_pend && m_wait > 0) begin
            n_wait = m_wait - 1;
        end else if (e_valid && Rsp_Ready) begin
            n_pend = 1'b0;
        end
    end

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pend <= 1'b0;
            m_wait <= 0;
        end else begin
            m_pend  <= n_pend;
            m_wait  <= n_wait;
            m_data  <= n_data;
            m_fault <= n_fault;
            if (n_we) begin
                m_mem[n_idx] <= n_wdata;
                m_wr[n_idx]  <= 1'b1;
            end
        end
    end

    logic        cap_en_w, cap_en_r;
    logic [29:0] cap_addr;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int waited);
        Req_Valid = 1'b1;
        Req_Write = w;
        Req_Addr  = a;
        Req_Data  = d;
        waited    = 0;
        @(negedge Clock);
        while (!Req_Ready && waited < 20) begin
            waited++;
            @(negedge Clock);
        end
        if (!Req_Ready) check("issue_timeout", 32'd0, 32'd1);
        cap_en_w = Mem_En_W;
        cap_en_r = Mem_En_R;
        cap_addr = Mem_Addr;
        tick();
        Req_Valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, hs0, lat;
        bit seen;
        Reset_n = 1'b0;
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = '0; Req_Data = '0;
        Rsp_Ready = 1'b1;
        Req_Valid3 = 1'b0; Req_Write3 = 1'b0; Req_Addr3 = '0; Req_Data3 = '0;
        Rsp_Ready3 = 1'b1;

        repeat (3) begin
            @(negedge Clock);
            check("rst_req_ready", 32'(Req_Ready), 32'd0);
            check("rst_en_r", 32'(Mem_En_R), 32'd0);
            check("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
            check("rst_rsp_data", Rsp_Data, 32'd0);
        end
        tick();
        Req_Valid = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clock);
        check("idle_req_ready", 32'(Req_Ready), 32'd1);
        tick();

        // Store / load round trip
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, w);
        check("st_en_w", 32'(cap_en_w), 32'd1);
        check("st_addr", 32'(cap_addr), 32'd4);
        @(negedge Clock);
        check("st_rsp_valid", 32'(Rsp_Valid), 32'd1);
        check("st_rsp_data", Rsp_Data, 32'd0);
        tick();
        issue(1'b0, 32'h0000_0010, 32'h0, w);
        check("ld_en_r", 32'(cap_en_r), 32'd1);
        @(negedge Clock);
        check("ld_early_valid", 32'(Rsp_Valid), 32'd0);
        tick();
        @(negedge Clock);
        check("ld_rsp_valid", 32'(Rsp_Valid), 32'd1);
        check("ld_rsp_data", Rsp_Data, 32'hDEAD_BEEF);
        check("ld_rsp_fault", 32'(Rsp_Fault), 32'd0);
        tick();

        // Faults and the highest legal word
        issue(1'b0, 32'h0000_0012, 32'h0, w);
        check("mis_en_r", 32'(cap_en_r), 32'd0);
        @(negedge Clock);
        check("mis_fault", 32'(Rsp_Fault), 32'd1);
        check("mis_data", Rsp_Data, 32'd0);
        tick();
        issue(1'b0, 32'h0000_4000, 32'h0, w);
        check("oor_en_r", 32'(cap_en_r), 32'd0);
        @(negedge Clock);
        check("oor_fault", 32'(Rsp_Fault), 32'd1);
        check("oor_valid", 32'(Rsp_Valid), 32'd1);
        tick();
        issue(1'b0, 32'h0000_3FFC, 32'h0, w);
        check("top_en_r", 32'(cap_en_r), 32'd1);
        check("top_addr", 32'(cap_addr), 32'hFFF);
        @(negedge Clock);
        tick();
        @(negedge Clock);
        check("top_data", Rsp_Data, init_word(32'hFFF));
        check("top_fault", 32'(Rsp_Fault), 32'd0);
        tick();

        // Backpressure, then a queued store taken in the handshake cycle
        Rsp_Ready = 1'b0;
        issue(1'b0, 32'h0000_0010, 32'h0, w);
        @(negedge Clock);
        tick();
        repeat (4) begin
            @(negedge Clock);
            check("bp_valid", 32'(Rsp_Valid), 32'd1);
            check("bp_data", Rsp_Data, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(Req_Ready), 32'd0);
            tick();
        end
        Rsp_Ready = 1'b1;
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, w);
        check("bp_accept_wait", w, 32'd0);
        check("bp_accept_en_w", 32'(cap_en_w), 32'd1);
        @(negedge Clock);
        check("bp_st_valid", 32'(Rsp_Valid), 32'd1);
        check("bp_st_data", Rsp_Data, 32'd0);
        tick();

        // Eight back-to-back stores
        hs0 = rsp_hs;
        for (int i = 0; i < 8; i++) begin
            Req_Valid = 1'b1;
            Req_Write = 1'b1;
            Req_Addr  = 32'(i * 4);
            Req_Data  = 32'hA0 + 32'(i);
            @(negedge Clock);
            check("tp_ready", 32'(Req_Ready), 32'd1);
            check("tp_en_w", 32'(Mem_En_W), 32'd1);
            check("tp_addr", 32'(Mem_Addr), 32'(i));
            tick();
        end
        Req_Valid = 1'b0;
        @(negedge Clock);
        #1;
        check("tp_responses", 32'(rsp_hs - hs0), 32'd8);
        tick();

        // Reset while a read is in flight
        issue(1'b0, 32'h0000_0020, 32'h0, w);
        Reset_n = 1'b0;
        @(negedge Clock);
        check("rw_rst_valid", 32'(Rsp_Valid), 32'd0);
        tick();
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check("rw_post_valid", 32'(Rsp_Valid), 32'd0);
            check("rw_post_ready", 32'(Req_Ready), 32'd1);
            tick();
        end

        // Latency-3 instance: response four cycles after accept
        Req_Valid3 = 1'b1;
        Req_Addr3  = 32'h0000_0020;
        Req_Data3  = 32'hCAFE_0001;
        @(negedge Clock);
        check("l3_ready", 32'(Req_Ready3), 32'd1);
        check("l3_en_r", 32'(Mem_En_R3), 32'd1);
        check("l3_en_w", 32'(Mem_En_W3), 32'd0);
        check("l3_addr", 32'(Mem_Addr3), 32'd8);
        check("l3_wdata", Mem_Data_W3, 32'hCAFE_0001);
        tick();
        Req_Valid3 = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge Clock);
            lat++;
            if (Rsp_Valid3) begin
                seen = 1'b1;
                check("l3_data", Rsp_Data3, init_word(8));
                check("l3_fault", 32'(Rsp_Fault3), 32'd0);
            end
            tick();
        end
        check("l3_latency", lat, 32'd4);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
